// File: rtl/rst_seq_pkg.sv
// Shared types and limits for the reset release sequencer.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    REL  = 2'd1,
    RUN  = 2'd2
  } rst_seq_state_e;

  localparam int STAGES_MIN     = 2;
  localparam int STAGES_MAX     = 8;
  localparam int NUM_CH_MIN     = 1;
  localparam int NUM_CH_MAX     = 16;
  localparam int GAP_MAX        = 255;
  localparam int MIN_ASSERT_MAX = 255;

  // Hold/gap counters only ever count up to their 8-bit-bounded parameters.
  localparam int CNT_W = $clog2(MIN_ASSERT_MAX + 1);

endpackage

// File: rtl/rst_sync_cell.sv
// Reset synchronizer: asserts asynchronously, deasserts after STAGES clk edges.
module rst_sync_cell #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_req,
  output logic sync_rst
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or posedge rst_req) begin
    if (rst_req) chain <= '1;
    else         chain <= {chain[STAGES-2:0], 1'b0};
  end

  assign sync_rst = chain[STAGES-1];

endmodule

// File: rtl/reset_release_sequencer.sv
// Staggered per-channel reset release after a synchronized reset request.
// Build option: define RSTSEQ_CH_REQ_EN to add the ch_req soft-reset port.
module reset_release_sequencer
  import rst_seq_pkg::*;
#(
  parameter int STAGES     = 2,
  parameter int NUM_CH     = 4,
  parameter int GAP_CYCLES = 3,
  parameter int MIN_ASSERT = 4
) (
  input  logic              clk,
  input  logic              rst_req,
`ifdef RSTSEQ_CH_REQ_EN
  input  logic [NUM_CH-1:0] ch_req,
`endif
  output logic [NUM_CH-1:0] rst_out,
  output logic              busy,
  output logic              all_released
);

  // idx reaches NUM_CH after the last release, so size for that value.
  localparam int IDX_W = $clog2(NUM_CH + 1);

  logic                 sync_rst;
  rst_seq_state_e       state, state_nxt;
  logic [CNT_W-1:0]     hold_cnt, hold_nxt;
  logic [CNT_W-1:0]     gap_cnt, gap_nxt;
  logic [IDX_W-1:0]     idx, idx_nxt;
  logic [NUM_CH-1:0]    seq_rst, seq_nxt;

  rst_sync_cell #(.STAGES(STAGES)) u_sync (
    .clk      (clk),
    .rst_req  (rst_req),
    .sync_rst (sync_rst)
  );

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    gap_nxt   = gap_cnt;
    idx_nxt   = idx;
    seq_nxt   = seq_rst;
    case (state)
      HOLD: begin
        if (sync_rst) begin
          hold_nxt = '0;
        end else if (hold_cnt == CNT_W'(MIN_ASSERT - 1)) begin
          hold_nxt   = '0;
          seq_nxt[0] = 1'b0;
          gap_nxt    = '0;
          idx_nxt    = IDX_W'(1);
          state_nxt  = (NUM_CH == 1) ? RUN : REL;
        end else begin
          hold_nxt = hold_cnt + CNT_W'(1);
        end
      end
      REL: begin
        if (gap_cnt == CNT_W'(GAP_CYCLES - 1)) begin
          seq_nxt = seq_rst & ~(NUM_CH'(1) << idx);
          idx_nxt = idx + IDX_W'(1);
          gap_nxt = '0;
          if (idx == IDX_W'(NUM_CH - 1)) state_nxt = RUN;
        end else begin
          gap_nxt = gap_cnt + CNT_W'(1);
        end
      end
      RUN:     ;
      default: state_nxt = HOLD;
    endcase
  end

  always_ff @(posedge clk or posedge rst_req) begin
    if (rst_req) begin
      state    <= HOLD;
      hold_cnt <= '0;
      gap_cnt  <= '0;
      idx      <= '0;
      seq_rst  <= '1;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
      gap_cnt  <= gap_nxt;
      idx      <= idx_nxt;
      seq_rst  <= seq_nxt;
    end
  end

`ifdef RSTSEQ_CH_REQ_EN
  // Soft requests only reach channels the sequence has already released.
  logic [NUM_CH-1:0] out_q;

  always_ff @(posedge clk or posedge rst_req) begin
    if (rst_req) out_q <= '1;
    else         out_q <= seq_nxt | (ch_req & ~seq_rst);
  end

  assign rst_out = out_q;
`else
  assign rst_out = seq_rst;
`endif

  assign busy         = (state != RUN);
  assign all_released = (state == RUN);

endmodule

// File: tb/tb_reset_release_sequencer.sv
// Directed bench for reset_release_sequencer (default params plus a NUM_CH=1 instance).
module tb_reset_release_sequencer;

  logic       clk = 1'b0;
  logic       rst_req;
  logic [3:0] rst_out;
  logic       busy, all_released;
  logic [0:0] rst_out1;
  logic       busy1, all_released1;
  int         errs   = 0;
  int         checks = 0;

`ifdef RSTSEQ_CH_REQ_EN
  logic [3:0] ch_req;
`endif

  always #5 clk = ~clk;

  reset_release_sequencer #(.STAGES(2), .NUM_CH(4), .GAP_CYCLES(3), .MIN_ASSERT(4)) dut (
    .clk          (clk),
    .rst_req      (rst_req),
`ifdef RSTSEQ_CH_REQ_EN
    .ch_req       (ch_req),
`endif
    .rst_out      (rst_out),
    .busy         (busy),
    .all_released (all_released)
  );

  reset_release_sequencer #(.STAGES(2), .NUM_CH(1), .GAP_CYCLES(3), .MIN_ASSERT(1)) dut1 (
    .clk          (clk),
    .rst_req      (rst_req),
`ifdef RSTSEQ_CH_REQ_EN
    .ch_req       (1'b0),
`endif
    .rst_out      (rst_out1),
    .busy         (busy1),
    .all_released (all_released1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Walks n edges after rst_req has gone low; edge e=1 is the first edge sampling it low.
  task automatic run_seq(input string tag, input int n, input int clr_e);
    logic [3:0] exp_out;
    for (int e = 1; e <= n; e++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 4; k++) exp_out[k] = (e < 2 + 4 + k * 3);
      chk($sformatf("%s rst_out e%0d", tag, e), 32'(rst_out), 32'(exp_out));
      chk($sformatf("%s busy e%0d", tag, e), 32'(busy), 32'(e < 15));
      chk($sformatf("%s all_rel e%0d", tag, e), 32'(all_released), 32'(e >= 15));
      chk($sformatf("%s n1 rst_out e%0d", tag, e), 32'(rst_out1), 32'(e < 3));
      chk($sformatf("%s n1 all_rel e%0d", tag, e), 32'(all_released1), 32'(e >= 3));
`ifdef RSTSEQ_CH_REQ_EN
      if (e == clr_e) ch_req = 4'h0;
`else
      if (e == clr_e) checks = checks + 0;
`endif
    end
  endtask

  initial begin
    rst_req = 1'b1;
`ifdef RSTSEQ_CH_REQ_EN
    ch_req = 4'h0;
`endif
    repeat (10) @(posedge clk);
    #1;
    chk("reset rst_out", 32'(rst_out), 32'hF);
    chk("reset busy", 32'(busy), 32'd1);
    chk("reset all_rel", 32'(all_released), 32'd0);
    chk("reset n1 rst_out", 32'(rst_out1), 32'd1);

    // Power-on release
    @(negedge clk) rst_req = 1'b0;
    run_seq("pwr", 16, 0);

    // 2 ns pulse from RUN, then partway into the sequence
    #2 rst_req = 1'b1;
    #1;
    chk("short async rst_out", 32'(rst_out), 32'hF);
    chk("short async busy", 32'(busy), 32'd1);
    #1 rst_req = 1'b0;
    run_seq("short", 10, 0);

    // One-cycle pulse mid-REL with ch0/ch1 released
    #1 rst_req = 1'b1;
    #1;
    chk("midrel async rst_out", 32'(rst_out), 32'hF);
    chk("midrel async all_rel", 32'(all_released), 32'd0);
    @(posedge clk); #2 rst_req = 1'b0;
    run_seq("midrel", 16, 0);

`ifdef RSTSEQ_CH_REQ_EN
    ch_req = 4'h4;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("soft rst_out c%0d", i), 32'(rst_out), 32'h4);
      chk($sformatf("soft all_rel c%0d", i), 32'(all_released), 32'd1);
    end
    ch_req = 4'h0;
    @(posedge clk); #1;
    chk("soft clear rst_out", 32'(rst_out), 32'h0);
    chk("soft clear all_rel", 32'(all_released), 32'd1);

    // ch3 request while still unreleased must be ignored
    #2 rst_req = 1'b1;
    #2 rst_req = 1'b0;
    ch_req = 4'h8;
    run_seq("unrel", 16, 14);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/reset_release_sequencer.md
RESET_RELEASE_SEQUENCER -- requirements
Module: reset_release_sequencer

Interface
REQ-001 SHALL have parameter STAGES, default 2, synchronizer depth, legal range 2..8.
REQ-002 SHALL have parameter NUM_CH, default 4, number of reset output channels, legal range 1..16.
REQ-003 SHALL have parameter GAP_CYCLES, default 3, clock cycles between successive channel releases, legal range 1..255.
REQ-004 SHALL have parameter MIN_ASSERT, default 4, minimum synchronous hold cycles before the first release, legal range 1..255.
REQ-005 SHALL have port clk, input, 1 bit, the single clock.
REQ-006 SHALL have port rst_req, input, 1 bit, asynchronous active-high reset request; it is the only reset of the block.
REQ-007 SHALL have port ch_req, input, NUM_CH bits, synchronous per-channel soft-reset request (present only under RSTSEQ_CH_REQ_EN).
REQ-008 SHALL have port rst_out, output, NUM_CH bits, active-high per-channel reset, bit 0 released first.
REQ-009 SHALL have port busy, output, 1 bit, high while the release sequence is incomplete.
REQ-010 SHALL have port all_released, output, 1 bit, high in state RUN.

Function
REQ-011 SHALL pass rst_req through a STAGES-deep chain that sets to all-ones asynchronously and shifts in 0 on each clk edge; sync_rst is the last stage.
REQ-012 SHALL implement an FSM with states HOLD, REL and RUN.
REQ-013 HOLD: rst_out all ones; hold counter cleared while sync_rst=1; counter increments while sync_rst=0.
REQ-014 HOLD exit: on the edge where the hold counter reaches MIN_ASSERT, rst_out[0] SHALL clear.
REQ-015 HOLD next state: if NUM_CH=1, go to RUN; otherwise go to REL with index 1 and gap counter 0.
REQ-016 REL: gap counter increments each edge; on the edge it reaches GAP_CYCLES, rst_out[index] SHALL clear, index SHALL increment and the gap counter SHALL clear.
REQ-017 REL exit: releasing index NUM_CH-1 SHALL move the FSM to RUN on that same edge.
REQ-018 Release timing: rst_out[k] falls exactly STAGES+MIN_ASSERT+k*GAP_CYCLES edges after the first edge sampling rst_req low.
REQ-019 RUN is terminal until rst_req reasserts.
REQ-020 busy SHALL equal (state != RUN); all_released SHALL equal (state == RUN); both are registered-state decodes with no combinational path from rst_req other than through reset.
REQ-021 rst_req assertion in any state, including mid-REL and mid-HOLD, SHALL set all rst_out to 1 and return to HOLD, which restarts the full sequence.
REQ-022 An rst_req pulse shorter than one clk period SHALL still produce a complete sequence.
REQ-023 All counters SHALL be sized to their parameter range; no wrap-around is reachable.

Reset
REQ-024 While rst_req=1, the block SHALL hold: rst_out all ones, busy=1, all_released=0, state HOLD, all counters 0, synchronizer all ones.
REQ-025 rst_out assertion SHALL be asynchronous and glitch-free; deassertion SHALL be synchronous to clk only.

Configuration
REQ-026 Macro RSTSEQ_CH_REQ_EN SHALL compile in the ch_req port and the soft-reset feature.
REQ-027 With RSTSEQ_CH_REQ_EN defined: for a channel already released, in REL or RUN, ch_req[i]=1 sampled at an edge SHALL set rst_out[i]=1 from that edge.
REQ-028 With RSTSEQ_CH_REQ_EN defined: rst_out[i] SHALL clear on the first edge sampling ch_req[i]=0.
REQ-029 With RSTSEQ_CH_REQ_EN defined: ch_req SHALL be ignored for unreleased channels and SHALL not affect the FSM, busy or all_released.
REQ-030 Without RSTSEQ_CH_REQ_EN: the ch_req port SHALL be absent and rst_out SHALL be driven by the sequence only.

Structure
REQ-031 Package rst_seq_pkg SHALL hold the FSM state enum (HOLD, REL, RUN) and the parameter range limit constants.
REQ-032 The synchronizer chain SHALL be sub-module rst_sync_cell (parameter STAGES; ports clk, rst_req, sync_rst), instantiated once.

Verification (STAGES=2, NUM_CH=4, GAP_CYCLES=3, MIN_ASSERT=4 unless stated)
REQ-033 Power-on: rst_req high 10 cycles then low -> rst_out=4'hF; bits 0/1/2/3 fall at edges 6/9/12/15; busy falls and all_released rises at edge 15.
REQ-034 rst_req 1-cycle pulse at edge 10 of a sequence (ch0 and ch1 released) -> rst_out=4'hF immediately (async), then a full sequence with ch0 at +6.
REQ-035 rst_req 2 ns pulse between edges -> a complete sequence identical to REQ-033 timing.
REQ-036 RSTSEQ_CH_REQ_EN, RUN, ch_req[2]=1 for 5 cycles -> rst_out=4'h4 for 5 cycles, then 0; all_released stays 1.
REQ-037 RSTSEQ_CH_REQ_EN, ch_req[3]=1 during REL before ch3 release -> no effect; ch3 falls at edge 15.
REQ-038 NUM_CH=1, MIN_ASSERT=1 -> rst_out[0] falls at edge 3 and all_released rises at edge 3.
